dac_slew_sequencer: RTL and testbench
=====================================

DAC_SLEW_SEQUENCER -- requirements
Module: dac_slew_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16'd1000, the number of clk cycles per slew tick (legal range 2..65535).
REQ-002 SHALL have parameter RESET_CODE, default 16'h0000, the reset value of all targets and outputs.
REQ-003 SHALL have port clk, input, 1 bit: 100 MHz system clock.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: target write strobe.
REQ-006 SHALL have port wr_addr, input, 3 bits: target channel index, 0..7 mapping to dac1..dac8.
REQ-007 SHALL have port wr_data, input, 16 bits: target code.
REQ-008 SHALL have port step, input, 16 bits: maximum code change per channel per tick.
REQ-009 SHALL have port convertEnd, input, 1 bit: downstream 8-channel SPI DAC driver idle flag.
REQ-010 SHALL have ports dac1..dac8, output, 16 bits each, registered: setpoints to the DAC driver.
REQ-011 SHALL have port busy, output, 1 bit: high while in SCAN or COMMIT.
REQ-012 SHALL have port settled, output, 1 bit, registered: high when every dacN equals its target.

Function
REQ-013 SHALL hold eight 16-bit target registers; wr_en=1 writes wr_data to target[wr_addr] at the clock edge, in any state.
REQ-014 SHALL run a tick counter 0..TICK_DIV-1 that wraps and emits a one-cycle tick when count==TICK_DIV-1.
REQ-015 SHALL set a single-bit pending flag on tick; further ticks while pending=1 coalesce (no queue).
REQ-016 SHALL implement FSM states IDLE, SCAN, COMMIT.
REQ-017 IDLE->SCAN when pending=1 and convertEnd=1; SHALL clear pending on that transition. pending=1 with convertEnd=0 remains in IDLE.
REQ-018 SCAN SHALL last exactly 8 cycles, processing channel index 0..7 in order, one channel per cycle, writing shadow[i].
REQ-019 Per channel, using unsigned 16-bit arithmetic: if target>cur and target-cur>step, shadow=cur+step; if target>cur otherwise, shadow=target; if target<cur and cur-target>step, shadow=cur-step; if target<cur otherwise, shadow=target; if target==cur, shadow=cur. No wrap-around is permitted.
REQ-020 step=0 SHALL freeze all outputs, with SCAN/COMMIT still executing.
REQ-021 COMMIT SHALL last 1 cycle and copy all eight shadows to dac1..dac8 simultaneously at the edge ending COMMIT, then return to IDLE.
REQ-022 SCAN of channel i SHALL use the target value registered before the current edge; a same-cycle write to channel i takes effect on the next tick.
REQ-023 Ticks occurring during SCAN/COMMIT SHALL set pending and be served from IDLE.
REQ-024 Latency: from pending=1 and convertEnd=1 in IDLE to updated dacN visible SHALL be 10 clk cycles (1 transition + 8 SCAN + 1 COMMIT).
REQ-025 settled SHALL be recomputed every cycle from committed outputs versus targets.
REQ-026 convertEnd dropping during SCAN/COMMIT SHALL NOT abort the sequence.

Reset
REQ-027 While reset=1: all targets, shadows, and dac1..dac8 = RESET_CODE; tick counter=0; pending=0; state=IDLE; busy=0; settled=1 on the cycle after reset.
REQ-028 Reset asserted mid-SCAN or COMMIT SHALL discard the shadows without committing them.

Verification (TICK_DIV=4, RESET_CODE=0)
REQ-029 Write target[0]=16'h0100 with step=16'h0040 and convertEnd=1 -> dac1 follows 0040, 0080, 00C0, 0100 on successive commits; settled=1 after the 4th commit.
REQ-030 Set dac3 at 16'hFFF0 with target 16'hFFFF and step=16'h0100 -> dac3=FFFF with no wrap; then target=0000 -> FEFF, FDFF, and so on down to 0000.
REQ-031 Hold convertEnd=0 for 20 cycles with target[7]=16'h0010 and step=1 -> dac8 stays 0 and busy=0; convertEnd=1 -> exactly one commit, dac8=0001 and not more, since ticks coalesced.
REQ-032 wr_en to channel 2 during the SCAN cycle for index 2 -> that commit uses the old target and the following commit uses the new one.
REQ-033 Assert reset on SCAN cycle 5 with pending steps -> all dacN=0 and state IDLE next cycle, with no partial commit.
REQ-034 step=0 with targets differing -> busy pulses every tick for 9 cycles, outputs unchanged, settled=0.

Source files
------------

// File: rtl/dac_slew_sequencer.sv
// Slew-rate-limited setpoint sequencer for an 8-channel SPI DAC driver.
// On each tick, every channel moves toward its target by at most `step`, and all channels commit together.
module dac_slew_sequencer #(
  parameter logic [15:0] TICK_DIV   = 16'd1000,
  parameter logic [15:0] RESET_CODE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [15:0] step,
  input  logic        convertEnd,
  output logic [15:0] dac1,
  output logic [15:0] dac2,
  output logic [15:0] dac3,
  output logic [15:0] dac4,
  output logic [15:0] dac5,
  output logic [15:0] dac6,
  output logic [15:0] dac7,
  output logic [15:0] dac8,
  output logic        busy,
  output logic        settled
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t      state;
  logic [15:0] tick_cnt;
  logic        tick;
  logic        pending;
  logic [2:0]  idx;
  logic [15:0] target [8];
  logic [15:0] shadow [8];
  logic [15:0] dac_q  [8];
  logic [15:0] cur, tgt, nxt;
  logic        all_eq;
  logic        go;

  assign tick = (tick_cnt == TICK_DIV - 16'd1);
  assign go   = (state == S_IDLE) && pending && convertEnd;

  // Compare before subtracting so neither direction can wrap.
  always_comb begin
    cur = dac_q[idx];
    tgt = target[idx];
    if (tgt > cur)
      nxt = ((tgt - cur) > step) ? cur + step : tgt;
    else if (tgt < cur)
      nxt = ((cur - tgt) > step) ? cur - step : tgt;
    else
      nxt = cur;
  end

  always_comb begin
    all_eq = 1'b1;
    for (int unsigned i = 0; i < 8; i++)
      if (dac_q[i] != target[i]) all_eq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      pending  <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      settled  <= 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
        target[i] <= RESET_CODE;
        shadow[i] <= RESET_CODE;
        dac_q[i]  <= RESET_CODE;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
      // A tick landing on the launch edge is a fresh request, so it survives the clear.
      pending  <= tick | (pending & ~go);
      settled  <= all_eq;
      if (wr_en) target[wr_addr] <= wr_data;

      case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_SCAN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          shadow[idx] <= nxt;
          idx         <= idx + 3'd1;
          if (idx == 3'd7) state <= S_COMMIT;
        end
        S_COMMIT: begin
          for (int unsigned i = 0; i < 8; i++) dac_q[i] <= shadow[i];
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dac1 = dac_q[0];
  assign dac2 = dac_q[1];
  assign dac3 = dac_q[2];
  assign dac4 = dac_q[3];
  assign dac5 = dac_q[4];
  assign dac6 = dac_q[5];
  assign dac7 = dac_q[6];
  assign dac8 = dac_q[7];

endmodule

// File: tb/tb_dac_slew_sequencer.sv
// Randomised and directed bench for dac_slew_sequencer with a cycle-level reference model
// and a commit scoreboard.
module tb_dac_slew_sequencer;

  localparam logic [15:0] TD = 16'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] step = '0;
  logic        convertEnd = 1'b1;
  logic [15:0] dac1, dac2, dac3, dac4, dac5, dac6, dac7, dac8;
  logic        busy, settled;

  dac_slew_sequencer #(.TICK_DIV(TD), .RESET_CODE(16'h0000)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step(step), .convertEnd(convertEnd),
    .dac1(dac1), .dac2(dac2), .dac3(dac3), .dac4(dac4),
    .dac5(dac5), .dac6(dac6), .dac7(dac7), .dac8(dac8),
    .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: a sequence is a phase number 0 (idle), 1..8 (channel phase-1), 9 (commit).
  int unsigned   k = 0;
  int            m_phase = 0;
  bit            m_pend = 0, m_busy = 0, m_settled = 1, edge_rst = 0, started = 0;
  logic [15:0]   m_tgt [8];
  logic [15:0]   m_dac [8];
  logic [15:0]   m_sh  [8];
  logic [127:0]  exp_q [$];

  function automatic logic [15:0] slew_ref(input logic [15:0] t, input logic [15:0] c,
                                           input logic [15:0] s);
    int d;
    d = int'(t) - int'(c);
    if (d > int'(s))  return c + s;
    if (d < -int'(s)) return c - s;
    return t;
  endfunction

  function automatic logic [127:0] model_vec();
    return {m_dac[0], m_dac[1], m_dac[2], m_dac[3], m_dac[4], m_dac[5], m_dac[6], m_dac[7]};
  endfunction

  always @(posedge clk) begin
    bit tick_now, launch, eq;
    started = 1;
    if (reset) begin
      k = 0; m_phase = 0; m_pend = 0; m_busy = 0; m_settled = 1; edge_rst = 1;
      for (int i = 0; i < 8; i++) begin m_tgt[i] = '0; m_dac[i] = '0; m_sh[i] = '0; end
    end else begin
      edge_rst = 0;
      tick_now = ((k % TD) == TD - 1);
      launch   = 0;
      eq = 1;
      for (int i = 0; i < 8; i++) if (m_dac[i] != m_tgt[i]) eq = 0;
      if (m_phase == 0) begin
        if (m_pend && convertEnd) begin launch = 1; m_phase = 1; end
      end else if (m_phase <= 8) begin
        m_sh[m_phase-1] = slew_ref(m_tgt[m_phase-1], m_dac[m_phase-1], step);
        m_phase++;
      end else begin
        for (int i = 0; i < 8; i++) m_dac[i] = m_sh[i];
        exp_q.push_back(model_vec());
        m_phase = 0;
      end
      m_pend = tick_now || (m_pend && !launch);
      if (wr_en) m_tgt[wr_addr] = wr_data;
      k++;
      m_settled = eq;
      m_busy = (m_phase != 0);
    end
  end

  // Monitor: per-cycle status checks plus a scoreboard pop whenever the DUT finishes a commit.
  bit prev_busy = 0;
  always @(negedge clk) begin
    logic [127:0] dv, e;
    if (started) begin
      dv = {dac1, dac2, dac3, dac4, dac5, dac6, dac7, dac8};
      total++;
      if (busy !== m_busy) begin
        bad++; $display("FAIL busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
      total++;
      if (settled !== m_settled) begin
        bad++; $display("FAIL settled t=%0t got=%b want=%b", $time, settled, m_settled);
      end
      if (edge_rst) begin
        total++;
        if (dv !== model_vec()) begin
          bad++; $display("FAIL reset_dacs t=%0t got=%h want=%h", $time, dv, model_vec());
        end
      end else if (prev_busy && !busy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL commit_unexpected t=%0t got=%h want=none", $time, dv);
        end else begin
          e = exp_q.pop_front();
          if (dv !== e) begin
            bad++; $display("FAIL commit_dacs t=%0t got=%h want=%h", $time, dv, e);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2); reset = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_phase != p && n < 200) begin cyc(1); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL wait_phase got=%0d want=%0d", m_phase, p);
    end
  endtask

  initial begin
    int pick;
    cyc(2);
    reset = 1'b0;

    // dac1 ramps 0x40 per commit up to 0x100
    step = 16'h0040; convertEnd = 1'b1;
    wr(3'd0, 16'h0100);
    cyc(80);

    // dac3: approach top of range, clamp at FFFF, then ramp down to 0
    step = 16'hFFFF; wr(3'd2, 16'hFFF0); cyc(30);
    step = 16'h0100; wr(3'd2, 16'hFFFF); cyc(30);
    wr(3'd2, 16'h0000); cyc(3200);

    // coalesced ticks while the driver is busy
    convertEnd = 1'b0; step = 16'h0001;
    wr(3'd7, 16'h0010); cyc(20);
    convertEnd = 1'b1; cyc(12);
    convertEnd = 1'b0; cyc(20);
    convertEnd = 1'b1;

    // write to channel 2 on the edge that scans channel 2
    step = 16'h0010; wr(3'd2, 16'h0100); cyc(30);
    wait_phase(3); wr(3'd2, 16'h0000); cyc(40);

    // reset during scan of channel 5
    wr(3'd4, 16'h4000); cyc(3);
    wait_phase(6); do_reset(); cyc(5);

    // step=0 freezes outputs while sequences still run
    step = 16'h0000; wr(3'd1, 16'h1234); wr(3'd6, 16'h0042); cyc(40);

    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 399) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) begin
        pick = $urandom_range(0, 3);
        step = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'h0001 :
               (pick == 2) ? 16'h0100 : 16'($urandom);
      end
      convertEnd = ($urandom_range(0, 4) != 0);
      cyc(1);
    end

    reset = 1'b0; wr_en = 1'b0; convertEnd = 1'b1;
    cyc(30);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain got=%0d want=0 pending commits", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
